img_scan_arbiter: RTL and testbench

- Shares the single-port image memory (8-bit pixels, 18-bit address) between the single-cycle CPU and a display scan-out path.
- CPU accesses always win the port, in the same cycle.
- In idle port cycles the block walks the frame linearly and prefetches pixels into a small show-ahead FIFO that the VGA pixel logic pops.
- Sits between the io decoder / CPU bus and the image memory; it drives the memory address and write-enable.

---
 rtl/img_scan_pkg.sv | 16 +
 rtl/img_scan_arbiter_if.sv | 27 ++
 rtl/sync_fifo_sa.sv | 68 ++++++
 rtl/img_scan_arbiter.sv | 105 ++++++++++
 tb/tb_img_scan_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/img_scan_pkg.sv
// Shared types and default sizes for the image-memory scan arbiter.
package img_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W     = 18;
    localparam int DEF_PIX_W      = 8;
    localparam int DEF_IMG_PIXELS = 65536;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/img_scan_arbiter_if.sv
// CPU/memory/pixel bus seen by the scan arbiter; slave is the arbiter side.
interface img_scan_arbiter_if
    import img_scan_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [ADDR_W-1:0] mem_adr;
    logic              mem_we;
    logic [PIX_W-1:0]  mem_rdata;
    logic              pix_pop;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;

    modport master (
        output cpu_req, cpu_we, cpu_adr, mem_rdata, pix_pop,
        input  mem_adr, mem_we, pix_data, pix_valid
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, mem_rdata, pix_pop,
        output mem_adr, mem_we, pix_data, pix_valid
    );
endinterface

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO with flush; the head holds the last popped value when empty.
module sync_fifo_sa #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] last;
    logic              do_pop;
    logic              do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign valid   = (count != '0);
    assign data    = valid ? store[rd_ptr] : last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_pop) begin
                last <= store[rd_ptr];
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is pure data and carries no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            store[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/img_scan_arbiter.sv
// Shares the image memory port between the CPU (always wins) and a linear
// frame scanner that prefetches pixels into a small show-ahead FIFO.
module img_scan_arbiter
    import img_scan_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int IMG_PIXELS = DEF_IMG_PIXELS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan_en,
    img_scan_arbiter_if.slave  bus,
    output logic               frame_done,
    output logic               underflow,
    output logic               busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] scan_adr;
    logic              inflight;
    logic              scan_en_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    used;
    logic              issue;
    logic              last_issue;
    logic              abort;

    // Credit counts data already in flight so a returning read always has a slot.
    assign used       = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue      = (state == SCAN) && !bus.cpu_req && (used < (CNT_W+1)'(FIFO_DEPTH));
    assign last_issue = (scan_adr == ADDR_W'(IMG_PIXELS - 1));
    assign abort      = ((state == SCAN) || (state == DRAIN)) && !scan_en;

    assign bus.mem_adr = bus.cpu_req ? bus.cpu_adr : scan_adr;
    assign bus.mem_we  = bus.cpu_req && bus.cpu_we;

    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (scan_en) state_nx = SCAN;
            end
            SCAN: begin
                if (abort)                    state_nx = IDLE;
                else if (issue && last_issue) state_nx = DRAIN;
            end
            DRAIN: begin
                if (abort)          state_nx = IDLE;
                else if (!inflight) state_nx = DONE;
            end
            DONE: begin
                state_nx = scan_en ? SCAN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            scan_adr  <= '0;
            inflight  <= 1'b0;
            scan_en_q <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nx;
            inflight  <= issue && !abort;
            scan_en_q <= scan_en;
            if (abort) begin
                scan_adr <= '0;
            end else if (issue) begin
                scan_adr <= last_issue ? '0 : scan_adr + ADDR_W'(1);
            end
            // A pop on empty in the same cycle as an enable edge still sets the flag.
            if (bus.pix_pop && (count == '0)) begin
                underflow <= 1'b1;
            end else if (scan_en && !scan_en_q) begin
                underflow <= 1'b0;
            end
        end
    end

    sync_fifo_sa #(
        .DATA_W (PIX_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (bus.mem_rdata),
        .pop       (bus.pix_pop),
        .flush     (abort),
        .data      (bus.pix_data),
        .valid     (bus.pix_valid),
        .count     (count)
    );

endmodule

// File: tb/tb_img_scan_arbiter.sv
// Bench for img_scan_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_img_scan_arbiter;
    localparam int ADDR_W = 18;
    localparam int PIX_W  = 8;
    localparam int IMG    = 8;
    localparam int DEPTH  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_SCAN  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scan_en = 1'b0;
    logic frame_done, underflow, busy;
    logic [7:0] wdata = 8'h00;
    logic [7:0] wmem [0:(1<<ADDR_W)-1];

    int n_vec = 0;
    int n_err = 0;

    int         m_st;
    int         m_adr;
    bit         m_inflight;
    bit         m_uf;
    bit         m_en_q;
    logic [7:0] m_last;
    logic [7:0] m_pend;
    logic [7:0] m_q[$];

    bit seq_on = 1'b0;
    int seq_idx = 0;

    img_scan_arbiter_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    img_scan_arbiter #(
        .ADDR_W     (ADDR_W),
        .PIX_W      (PIX_W),
        .IMG_PIXELS (IMG),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_en    (scan_en),
        .bus        (bus),
        .frame_done (frame_done),
        .underflow  (underflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_of(input int a);
        return 8'(32'h10 + a);
    endfunction

    // Frame region is preloaded with 0x10+addr; the rest behaves as plain RAM.
    always @(posedge clk) begin
        if (bus.mem_we) wmem[bus.mem_adr] <= wdata;
        if (int'(bus.mem_adr) < IMG) bus.mem_rdata <= pix_of(int'(bus.mem_adr));
        else                         bus.mem_rdata <= wmem[bus.mem_adr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_adr = 0; m_inflight = 0; m_uf = 0; m_en_q = 0;
        m_last = 8'h00; m_pend = 8'h00; m_q.delete();
    endtask

    task automatic model_step(input bit en, input bit req, input bit pop);
        int used;
        bit issue, abort, infl_nx;
        used  = m_q.size() + int'(m_inflight);
        issue = (m_st == M_SCAN) && !req && (used < DEPTH);
        abort = ((m_st == M_SCAN) || (m_st == M_DRAIN)) && !en;
        if (pop && m_q.size() == 0) m_uf = 1;
        else if (en && !m_en_q)     m_uf = 0;
        m_en_q = en;
        if (pop && m_q.size() != 0) m_last = m_q.pop_front();
        infl_nx = 0;
        if (abort) begin
            m_q.delete(); m_adr = 0; m_st = M_IDLE;
        end else begin
            if (m_inflight) m_q.push_back(m_pend);
            case (m_st)
                M_IDLE:  if (en) m_st = M_SCAN;
                M_SCAN:  if (issue) begin
                    m_pend = pix_of(m_adr); infl_nx = 1;
                    if (m_adr == IMG - 1) begin m_adr = 0; m_st = M_DRAIN; end
                    else m_adr++;
                end
                M_DRAIN: if (!m_inflight) m_st = M_DONE;
                default: m_st = en ? M_SCAN : M_IDLE;
            endcase
        end
        m_inflight = infl_nx;
    endtask

    task automatic check_outputs();
        logic [7:0] exp_pix;
        if (m_q.size() != 0) exp_pix = m_q[0];
        else                 exp_pix = m_last;
        check("mem_adr", 32'(bus.mem_adr), bus.cpu_req ? 32'(bus.cpu_adr) : 32'(m_adr));
        check("mem_we", 32'(bus.mem_we), 32'(bus.cpu_req & bus.cpu_we));
        check("pix_valid", 32'(bus.pix_valid), 32'(m_q.size() != 0));
        check("pix_data", 32'(bus.pix_data), 32'(exp_pix));
        check("frame_done", 32'(frame_done), 32'(m_st == M_DONE));
        check("busy", 32'(busy), 32'(m_st != M_IDLE));
        check("underflow", 32'(underflow), 32'(m_uf));
    endtask

    task automatic tick(input bit en, input bit req, input bit we, input logic [ADDR_W-1:0] adr, input bit pop);
        scan_en = en; bus.cpu_req = req; bus.cpu_we = we; bus.cpu_adr = adr; bus.pix_pop = pop;
        wdata = 8'($urandom);
        @(negedge clk);
        check_outputs();
        if (seq_on && pop && bus.pix_valid) begin
            check("seq", 32'(bus.pix_data), 32'(pix_of(seq_idx)));
            seq_idx = (seq_idx + 1) % IMG;
        end
        model_step(en, req, pop);
        @(posedge clk); #1;
    endtask

    initial begin
        bit r_en, r_req, r_we, r_pop;
        logic [ADDR_W-1:0] r_adr;

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = '0; bus.pix_pop = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_outputs();
        reset = 1'b0;

        // Fill with no consumer: four issues, then the credit stops the scanner.
        for (int c = 0; c < 10; c++) tick(1, 0, 0, '0, 0);
        check("fill_valid", 32'(bus.pix_valid), 32'd1);
        check("fill_head", 32'(bus.pix_data), 32'h10);
        tick(1, 0, 0, '0, 1);

        // Asynchronous reset in the middle of a scan.
        reset = 1'b1; #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_data", 32'(bus.pix_data), 32'd0);
        check("rst_adr", 32'(bus.mem_adr), 32'd0);
        check("rst_uf", 32'(underflow), 32'd0);
        model_reset();
        scan_en = 1'b0; bus.cpu_req = 1'b0; bus.pix_pop = 1'b0;
        #2 reset = 1'b0;
        model_step(0, 0, 0);
        @(posedge clk); #1;
        tick(0, 1, 0, 18'h2ABCD, 0);

        // Continuous consumer with a CPU burst; pixel order must stay contiguous.
        seq_on = 1'b1; seq_idx = 0;
        for (int c = 0; c < 40; c++) tick(1, (c >= 10 && c <= 12), 1, 18'h3FFFF, 1);
        seq_on = 1'b0;

        // Abort with data in flight.
        tick(0, 0, 0, '0, 0);
        tick(0, 0, 0, '0, 0);
        for (int c = 0; c < 4; c++) tick(1, 0, 0, '0, 0);
        tick(0, 0, 0, '0, 0);
        check("abort_valid", 32'(bus.pix_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick(0, 0, 0, '0, 0);
        check("abort_nodone", 32'(frame_done), 32'd0);

        // Underflow is sticky until the next enable edge.
        tick(1, 0, 0, '0, 1);
        for (int c = 0; c < 3; c++) tick(1, 0, 0, '0, 0);
        check("uf_sticky", 32'(underflow), 32'd1);
        tick(0, 0, 0, '0, 0);
        tick(1, 0, 0, '0, 0);
        check("uf_clear", 32'(underflow), 32'd0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            r_en  = ($urandom_range(99) < 96);
            r_req = ($urandom_range(99) < 25);
            r_we  = $urandom_range(1);
            r_pop = ($urandom_range(99) < 60);
            if (r_we) r_adr = ADDR_W'($urandom_range((1 << ADDR_W) - 1, IMG));
            else      r_adr = ADDR_W'($urandom);
            tick(r_en, r_req, r_we, r_adr, r_pop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
